// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared state encodings and datapath width for the memory stage
package mem_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

endpackage

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - LDUR/STUR memory-access stage with req/ack memory port
// Optional misalignment trap: MEM_ACCESS_ALIGN_CHECK_EN
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = mem_stage_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] ALU_Result,
  input  logic [DATA_W-1:0] Write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic              ready_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              align_fault
);

  logic [0:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              align_fault_q, align_fault_d;
  logic              mem_op;
  logic              misaligned;

  assign mem_op = MemRead | MemWrite;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misaligned = (ALU_Result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    wb_valid_d    = 1'b0;
    wb_data_d     = wb_data_q;
    align_fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && !mem_op) begin
          wb_data_d  = ALU_Result;
          wb_valid_d = 1'b1;
        end else if (valid_in && misaligned) begin
          align_fault_d = 1'b1;
        end else if (valid_in) begin
          // Read+write together resolves to a store via mem_we.
          mem_addr_d  = ALU_Result;
          mem_wdata_d = Write_data;
          mem_we_d    = MemWrite;
          mem_req_d   = 1'b1;
          state_d     = WAIT;
        end
      end
      default: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!mem_we_q) begin
            wb_data_d  = mem_rdata;
            wb_valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      align_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      align_fault_q <= align_fault_d;
    end
  end

  assign ready_out   = (state_q == IDLE) && !reset;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign align_fault = align_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  logic              clk = 1'b0;
  logic              reset, valid_in, MemRead, MemWrite, mem_ack;
  logic [DATA_W-1:0] ALU_Result, Write_data, mem_rdata;
  logic              ready_out, mem_req, mem_we, wb_valid, align_fault;
  logic [DATA_W-1:0] mem_addr, mem_wdata, wb_data;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] sb[$];
  logic [DATA_W-1:0] last_wb;

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] alu;
    logic              exp_v;
    logic [DATA_W-1:0] exp_d;
  } alu_vec_t;

  typedef struct {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                k;
  } ld_vec_t;

  alu_vec_t alu_tbl[5];
  ld_vec_t  ld_tbl[3];

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ALU_Result(ALU_Result),
    .Write_data(Write_data), .MemRead(MemRead), .MemWrite(MemWrite),
    .ready_out(ready_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_data(wb_data),
    .align_fault(align_fault)
  );

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard: every write-back pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wb_unexpected: got pulse with 0x%08h expected none", wb_data);
      end else begin
        chk("wb_order", wb_data, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] wd,
                       input logic rd, input logic wr);
    valid_in   = v;
    ALU_Result = a;
    Write_data = wd;
    MemRead    = rd;
    MemWrite   = wr;
  endtask

  task automatic do_load(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d, input int k);
    drive(1'b1, a, 32'h0, 1'b1, 1'b0);
    sb.push_back(d);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk1("ld_req", mem_req, 1'b1);
    chk("ld_addr", mem_addr, a);
    chk1("ld_we", mem_we, 1'b0);
    chk1("ld_ready_busy", ready_out, 1'b0);
    for (int i = 1; i < k; i++) begin
      step();
      chk1("ld_req_hold", mem_req, 1'b1);
      chk("ld_addr_hold", mem_addr, a);
      chk1("ld_wb_quiet", wb_valid, 1'b0);
    end
    mem_ack   = 1'b1;
    mem_rdata = d;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    chk1("ld_req_drop", mem_req, 1'b0);
    chk1("ld_ready_back", ready_out, 1'b1);
    chk1("ld_wb_valid", wb_valid, 1'b1);
    chk("ld_wb_data", wb_data, d);
    last_wb = d;
    step();
    chk1("ld_wb_pulse_end", wb_valid, 1'b0);
  endtask

  task automatic do_store(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] wd, input logic rd);
    drive(1'b1, a, wd, rd, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk1("st_req", mem_req, 1'b1);
    chk1("st_we", mem_we, 1'b1);
    chk("st_addr", mem_addr, a);
    chk("st_wdata", mem_wdata, wd);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk1("st_req_drop", mem_req, 1'b0);
    chk1("st_no_wb", wb_valid, 1'b0);
    chk("st_wb_keep", wb_data, last_wb);
    chk1("st_ready_back", ready_out, 1'b1);
  endtask

  initial begin
    alu_tbl[0] = '{1'b1, 32'h0000_1234, 1'b1, 32'h0000_1234};
    alu_tbl[1] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
    alu_tbl[2] = '{1'b0, 32'h0000_AAAA, 1'b0, 32'hFFFF_FFFF};
    alu_tbl[3] = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000};
    alu_tbl[4] = '{1'b0, 32'h1357_9BDF, 1'b0, 32'h0000_0000};
    ld_tbl[0]  = '{32'h0000_0040, 32'hDEAD_BEEF, 3};
    ld_tbl[1]  = '{32'h0000_0044, 32'h0000_0000, 1};
    ld_tbl[2]  = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 2};

    reset = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    chk1("rst_ready_low", ready_out, 1'b0);
    reset = 1'b0;
    #1;
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk1("rst_align", align_fault, 1'b0);
    chk1("rst_ready_high", ready_out, 1'b1);
    last_wb = 32'h0;

    for (int i = 0; i < 5; i++) begin
      drive(alu_tbl[i].v, alu_tbl[i].alu, 32'h0, 1'b0, 1'b0);
      if (alu_tbl[i].exp_v) sb.push_back(alu_tbl[i].exp_d);
      step();
      chk1("alu_wb_valid", wb_valid, alu_tbl[i].exp_v);
      chk("alu_wb_data", wb_data, alu_tbl[i].exp_d);
      chk1("alu_no_req", mem_req, 1'b0);
      chk1("alu_ready", ready_out, 1'b1);
    end
    last_wb = 32'h0;

    for (int i = 0; i < 3; i++) do_load(ld_tbl[i].addr, ld_tbl[i].data, ld_tbl[i].k);

    do_store(32'h0000_0080, 32'h5A5A_5A5A, 1'b0);
    do_store(32'h0000_0084, 32'hA5A5_0001, 1'b1);

    // Load followed by an ALU op that upstream holds while the stage is busy.
    drive(1'b1, 32'h0000_0100, 32'h0, 1'b1, 1'b0);
    sb.push_back(32'hCAFE_F00D);
    step();
    drive(1'b1, 32'h0000_7777, 32'h0, 1'b0, 1'b0);
    sb.push_back(32'h0000_7777);
    step();
    chk1("b2b_hold_wb", wb_valid, 1'b0);
    chk1("b2b_hold_ready", ready_out, 1'b0);
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack = 1'b0;
    chk("b2b_load_data", wb_data, 32'hCAFE_F00D);
    chk1("b2b_ready", ready_out, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk1("b2b_alu_valid", wb_valid, 1'b1);
    chk("b2b_alu_data", wb_data, 32'h0000_7777);
    step();
    chk1("b2b_quiet", wb_valid, 1'b0);

    // Reset while a load waits for its acknowledge.
    drive(1'b1, 32'h0000_0200, 32'h1111_2222, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk1("rw_req", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    chk1("rw_ready_in_reset", ready_out, 1'b0);
    step();
    reset = 1'b0;
    #1;
    chk1("rw_req_cleared", mem_req, 1'b0);
    chk("rw_addr_cleared", mem_addr, 32'h0);
    chk("rw_wb_cleared", wb_data, 32'h0);
    chk1("rw_ready", ready_out, 1'b1);
    mem_ack = 1'b1;
    mem_rdata = 32'hEEEE_EEEE;
    step();
    mem_ack = 1'b0;
    chk1("rw_stray_ack_wb", wb_valid, 1'b0);
    chk1("rw_stray_ack_req", mem_req, 1'b0);
    chk("rw_stray_ack_data", wb_data, 32'h0);
    last_wb = 32'h0;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    drive(1'b1, 32'h0000_0042, 32'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk1("al_fault", align_fault, 1'b1);
    chk1("al_no_req", mem_req, 1'b0);
    chk1("al_no_wb", wb_valid, 1'b0);
    chk1("al_ready", ready_out, 1'b1);
    step();
    chk1("al_fault_end", align_fault, 1'b0);
`else
    do_load(32'h0000_0042, 32'h0042_0042, 2);
    chk1("al_tied_zero", align_fault, 1'b0);
`endif

    step();
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage directly downstream of the processor ALU. It consumes the ALU result and the store data, and performs LDUR/STUR accesses to data memory over a request/acknowledge handshake. It stalls upstream while an access is outstanding, and delivers a registered write-back value (the loaded word or the passed-through ALU result) to the write-back mux.

## Interface
- DATA_W, 32, datapath and address width (ALU_Result width)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- valid_in  in  1  instruction present at stage input this cycle
- ALU_Result  in  DATA_W  effective address (LDUR/STUR) or pass-through result
- Write_data  in  DATA_W  store data (Read_data2)
- MemRead  in  1  load
- MemWrite  in  1  store
- ready_out  out  1  stage can accept; upstream must hold its instruction while 0
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, registered
- mem_addr  out  DATA_W  registered address
- mem_wdata  out  DATA_W  registered store data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  memory completes the request on this edge
- wb_valid  out  1  one-cycle pulse: wb_data is new and must be written back
- wb_data  out  DATA_W  registered write-back value
- align_fault  out  1  one-cycle misalignment pulse; constant 0 without the macro

## Operation
- FSM with two states: IDLE and WAIT.
- ready_out = (state == IDLE) && !reset.
- IDLE, valid_in=0: no action. wb_valid=0.
- IDLE, valid_in=1, MemRead=0, MemWrite=0 (ALU op):
  - wb_data <= ALU_Result; wb_valid <= 1.
  - Remain in IDLE, so back-to-back ALU ops sustain one per cycle.
- IDLE, valid_in=1, MemRead or MemWrite:
  - Latch mem_addr <= ALU_Result, mem_wdata <= Write_data, mem_we <= MemWrite.
  - mem_req <= 1; go to WAIT.
- MemRead=1 and MemWrite=1 together is illegal; it is executed as a store.
- WAIT:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack is sampled high.
  - On mem_ack: mem_req <= 0; go to IDLE.
  - Load: wb_data <= mem_rdata; wb_valid <= 1.
  - Store: wb_valid stays 0, and wb_data is unchanged.
- mem_ack sampled while mem_req=0 is ignored.
- wb_data holds its last value between pulses.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_data=0, align_fault=0.
- Reset during WAIT aborts the access. mem_req is 0 after the reset edge, and any late mem_ack is ignored.

## Timing
- ALU op accepted at edge N: wb_valid high in cycle N+1.
- Memory op accepted at edge N: mem_req high from cycle N+1.
  - mem_ack is sampled at edge N+k, k>=1.
  - Load wb_valid is high in cycle N+k+1.
  - ready_out returns to 1 in cycle N+k+1, so the next instruction can be accepted at edge N+k+1.
- Minimum load/store occupancy: 2 cycles.
- No combinational path from mem_rdata or mem_ack to any output.
- ready_out depends only on state and reset.

## Configuration
- MEM_ACCESS_ALIGN_CHECK_EN defined:
  - A memory op accepted in IDLE with ALU_Result[1:0] != 2'b00 issues no request.
  - align_fault <= 1 for one cycle, wb_valid stays 0, and the FSM stays in IDLE.
- Not defined: addresses pass to mem_addr unmodified, and align_fault is tied 0.

## Structure
- Shared package/header mem_stage_pkg holds:
  - the state encodings, IDLE=1'b0 and WAIT=1'b1
  - the DATA_W default
- The same package is used by the ALU-side pipeline and the testbench.
- Single module; no sub-module is warranted.

## Test plan
- ALU pass-through: valid_in=1, MemRead=MemWrite=0, ALU_Result=0x0000_1234 → wb_valid pulse in the next cycle, wb_data=0x0000_1234, mem_req stays 0.
- Load with 3-cycle memory: ALU_Result=0x40, MemRead=1 → mem_req=1, mem_addr=0x40, mem_we=0, ready_out=0 until ack. Ack with mem_rdata=0xDEAD_BEEF → wb_data=0xDEAD_BEEF, wb_valid for 1 cycle, ready_out=1.
- Store, ack in the first request cycle: ALU_Result=0x80, Write_data=0x5A5A_5A5A, MemWrite=1 → mem_we=1, mem_wdata=0x5A5A_5A5A. After ack, mem_req=0, no wb_valid, and wb_data keeps its old value.
- Back-to-back: load then ALU op held by upstream while ready_out=0 → the ALU op is accepted only on the edge after ack, and wb_valid pulses occur in order (load data, then ALU result).
- Reset in WAIT: assert reset for 1 cycle before ack → all outputs 0 and state IDLE. A subsequent stray mem_ack produces no wb_valid.
- With MEM_ACCESS_ALIGN_CHECK_EN: MemRead at 0x42 → align_fault pulse, mem_req=0, wb_valid=0. Without the macro, the same stimulus issues mem_req with mem_addr=0x42.
